seg_bus_reader: RTL and testbench

- Passive monitor for the multiplexed seven-segment display bus that our segment decoders and scanner drive.
- Samples the active-low anode selects and active-high segment lines, waits for each digit's pattern to settle, and decodes it back to a 4-bit digit value plus a status code.
- Used in the stopwatch/PWM designs as an on-chip readback of what the display actually shows, for self-check and for driving LEDs or a UART dump.

---
 rtl/seg_bus_reader.sv | 189 ++++++++++++++++++
 tb/tb_seg_bus_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_bus_reader.sv
// seg_bus_reader: passive readback of a multiplexed seven-segment bus.
// Settles each digit's pattern, then decodes it to value/status/dp.

module seg_bus_reader #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYC = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [7:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [2*NUM_DIGITS-1:0] digit_sts,
  output logic [NUM_DIGITS-1:0]   digit_dp,
  output logic                    frame_done,
  output logic                    err
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);
  localparam logic [7:0] FULL = 8'(STABLE_CYC);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t r_state, w_state_nx;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [7:0]              r_seg;
  logic [7:0]              r_rseg;
  logic [7:0]              r_cnt, w_cnt_nx;
  logic [IW-1:0]           r_idx, w_idx;
  logic [3:0]              w_nlow;
  logic                    w_legal, w_ill, w_same;
  logic                    w_rec, w_fire, r_fire;
  logic [3:0]              w_dval;
  logic [1:0]              w_dsts;
  logic [NUM_DIGITS-1:0]   w_kbit;
  logic [4*NUM_DIGITS-1:0] r_val;
  logic [2*NUM_DIGITS-1:0] r_sts;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic                    r_fd, r_err;

  assign digit_val  = r_val;
  assign digit_sts  = r_sts;
  assign digit_dp   = r_dp;
  assign frame_done = r_fd;
  assign err        = r_err;

  // Count lit anodes and find the index of the lit one.
  always_comb begin
    w_nlow = '0;
    w_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_an[i]) begin
        w_nlow = w_nlow + 4'd1;
        w_idx  = IW'(i);
      end
    end
  end

  assign w_legal = (w_nlow == 4'd1);
  assign w_ill   = (w_nlow > 4'd1);
  assign w_same  = (w_idx == r_idx) && (r_seg == r_rseg);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rec      = 1'b0;
    w_fire     = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        w_cnt_nx = '0;
        if (w_legal) begin
          w_rec      = 1'b1;
          w_cnt_nx   = 8'd1;
          w_state_nx = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!w_legal) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = '0;
        end else if (!w_same) begin
          w_rec    = 1'b1;
          w_cnt_nx = 8'd1;
        end else if (r_cnt == LAST) begin
          w_cnt_nx   = FULL;
          w_fire     = 1'b1;
          w_state_nx = S_HOLD;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (!w_legal) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = '0;
        end else if (!w_same) begin
          w_rec      = 1'b1;
          w_cnt_nx   = 8'd1;
          w_state_nx = S_SETTLE;
        end
      end
      default: begin
        w_state_nx = S_WAIT;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // dp is excluded from the decode; it is latched separately.
  always_comb begin
    w_dval = 4'd0;
    w_dsts = 2'b01;
    case (r_rseg[6:0])
      7'h3F: w_dval = 4'd0;
      7'h06: w_dval = 4'd1;
      7'h5B: w_dval = 4'd2;
      7'h4F: w_dval = 4'd3;
      7'h66: w_dval = 4'd4;
      7'h6D: w_dval = 4'd5;
      7'h7D: w_dval = 4'd6;
      7'h07: w_dval = 4'd7;
      7'h7F: w_dval = 4'd8;
      7'h6F: w_dval = 4'd9;
      7'h40: w_dsts = 2'b10;
      7'h00: w_dsts = 2'b00;
      default: w_dsts = 2'b11;
    endcase
  end

  always_comb begin
    w_kbit = '0;
    w_kbit[r_idx] = r_fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an    <= '1;
      r_seg   <= '0;
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rseg  <= '0;
      r_fire  <= 1'b0;
    end else begin
      r_an    <= an;
      r_seg   <= seg;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_fire  <= w_fire;
      if (w_rec) begin
        r_idx  <= w_idx;
        r_rseg <= r_seg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_val  <= '0;
      r_sts  <= '0;
      r_dp   <= '0;
      r_mask <= '0;
      r_fd   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (r_fire) begin
        r_val[4*r_idx +: 4] <= w_dval;
        r_sts[2*r_idx +: 2] <= w_dsts;
        r_dp[r_idx]         <= r_rseg[7];
      end
      r_err <= r_err | w_ill | (r_fire & (w_dsts == 2'b11));
      // A full mask pulses and clears; a same-cycle latch survives it.
      if (&r_mask) begin
        r_fd   <= 1'b1;
        r_mask <= w_kbit;
      end else begin
        r_fd   <= 1'b0;
        r_mask <= r_mask | w_kbit;
      end
    end
  end

endmodule

// File: tb/tb_seg_bus_reader.sv
// tb_seg_bus_reader: directed and random bus traffic checked each
// cycle against a run-length reference model of the display reader.

module tb_seg_bus_reader;
  localparam int ND = 4;
  localparam int SC = 16;
  localparam logic [6:0] PATS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic          clk = 1'b0;
  logic          reset;
  logic [ND-1:0] an;
  logic [7:0]    seg;
  logic [4*ND-1:0] digit_val;
  logic [2*ND-1:0] digit_sts;
  logic [ND-1:0]   digit_dp;
  logic            frame_done;
  logic            err;

  always #5 clk = ~clk;

  seg_bus_reader #(
    .NUM_DIGITS(ND),
    .STABLE_CYC(SC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .an        (an),
    .seg       (seg),
    .digit_val (digit_val),
    .digit_sts (digit_sts),
    .digit_dp  (digit_dp),
    .frame_done(frame_done),
    .err       (err)
  );

  typedef struct {
    int         due;
    int         k;
    logic [7:0] s;
  } lat_t;

  int compared   = 0;
  int mismatched = 0;
  int n          = 0;
  int fd_seen    = 0;

  lat_t lat_q[$];
  int   err_q[$];
  logic [3:0] e_val [ND];
  logic [1:0] e_sts [ND];
  logic       e_dp  [ND];
  logic       e_fd, e_err;
  logic [ND-1:0] seen;
  logic [ND-1:0] p_an;
  logic [7:0]    p_seg;
  int            run;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    run = 0;
    lat_q.delete();
    err_q.delete();
    for (int i = 0; i < ND; i++) begin
      e_val[i] = '0;
      e_sts[i] = '0;
      e_dp[i]  = 1'b0;
    end
    e_fd  = 1'b0;
    e_err = 1'b0;
    seen  = '0;
    p_an  = '1;
    p_seg = '0;
  endfunction

  function automatic void apply_latch(input lat_t l);
    logic [3:0] v;
    logic [1:0] st;
    v  = 4'd0;
    st = 2'b11;
    if (l.s[6:0] == 7'h40) st = 2'b10;
    else if (l.s[6:0] == 7'h00) st = 2'b00;
    else begin
      for (int d = 0; d < 10; d++)
        if (PATS[d] == l.s[6:0]) begin
          st = 2'b01;
          v  = 4'(d);
        end
    end
    if (st == 2'b11) e_err = 1'b1;
    e_val[l.k] = v;
    e_sts[l.k] = st;
    e_dp[l.k]  = l.s[7];
    seen[l.k]  = 1'b1;
  endfunction

  // Called once per clock edge, after the edge, with the sampled inputs.
  function automatic void model_edge();
    int nlow;
    int idx;
    e_fd = (seen == '1);
    if (e_fd) seen = '0;
    while (lat_q.size() > 0 && lat_q[0].due == n)
      apply_latch(lat_q.pop_front());
    while (err_q.size() > 0 && err_q[0] == n) begin
      e_err = 1'b1;
      void'(err_q.pop_front());
    end
    nlow = 0;
    idx  = 0;
    for (int i = 0; i < ND; i++)
      if (!an[i]) begin
        nlow++;
        idx = i;
      end
    if (nlow == 1 && run > 0 && an == p_an && seg == p_seg) run++;
    else if (nlow == 1) run = 1;
    else run = 0;
    if (nlow == 1 && run == SC) lat_q.push_back('{n + 2, idx, seg});
    if (nlow > 1) err_q.push_back(n + 1);
    p_an  = an;
    p_seg = seg;
  endfunction

  task automatic check_all(input string tag);
    logic [4*ND-1:0] v;
    logic [2*ND-1:0] s;
    logic [ND-1:0]   d;
    for (int i = 0; i < ND; i++) begin
      v[4*i +: 4] = e_val[i];
      s[2*i +: 2] = e_sts[i];
      d[i]        = e_dp[i];
    end
    chk({tag, ".val"}, 32'(digit_val), 32'(v));
    chk({tag, ".sts"}, 32'(digit_sts), 32'(s));
    chk({tag, ".dp"},  32'(digit_dp),  32'(d));
    chk({tag, ".fd"},  32'(frame_done), 32'(e_fd));
    chk({tag, ".err"}, 32'(err), 32'(e_err));
  endtask

  task automatic cyc(input logic [ND-1:0] a, input logic [7:0] s,
                     input int k);
    repeat (k) begin
      an  = a;
      seg = s;
      @(posedge clk);
      n++;
      model_edge();
      #1;
      if (frame_done) fd_seen++;
      check_all("cyc");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    chk("rst.val0", 32'(digit_val), 32'd0);
    chk("rst.sts0", 32'(digit_sts), 32'd0);
    @(posedge clk);
    n++;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [ND-1:0] a;
    logic [7:0]    s;
    an    = '1;
    seg   = '0;
    reset = 1'b1;
    do_reset();

    // single digit: exact latency
    repeat (17) cyc(4'b1110, 8'h5B, 1);
    chk("t1.early", 32'(digit_sts[1:0]), 32'd0);
    cyc(4'b1110, 8'h5B, 1);
    chk("t1.sts", 32'(digit_sts[1:0]), 32'd1);
    chk("t1.val", 32'(digit_val[3:0]), 32'd2);
    cyc(4'b1110, 8'h5B, 2);
    chk("t1.others", 32'(digit_sts[7:2]), 32'd0);
    chk("t1.err", 32'(err), 32'd0);

    // scan with gaps
    fd_seen = 0;
    for (int d = 0; d < 4; d++) begin
      a = ~(4'b0001 << d);
      case (d)
        0: s = 8'h3F;
        1: s = 8'h06;
        2: s = 8'h40;
        default: s = 8'hEF;
      endcase
      cyc(a, s, 32);
      cyc(4'b1111, 8'h00, 4);
    end
    chk("t2.val", 32'(digit_val), 32'h9010);
    chk("t2.sts", 32'(digit_sts), 32'h65);
    chk("t2.dp", 32'(digit_dp), 32'h8);
    chk("t2.fd", 32'(fd_seen), 32'd1);

    // toggling pattern never settles
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc(4'b1110, (i % 2) ? 8'h5B : 8'h06, 10);
    chk("t3.val", 32'(digit_val), 32'd0);
    chk("t3.sts", 32'(digit_sts), 32'd0);

    // illegal anode, then invalid pattern
    cyc(4'b1100, 8'h3F, 3);
    chk("t4.err", 32'(err), 32'd1);
    cyc(4'b1101, 8'h79, 20);
    chk("t4.sts", 32'(digit_sts[3:2]), 32'd3);
    chk("t4.val", 32'(digit_val[7:4]), 32'd0);
    chk("t4.sticky", 32'(err), 32'd1);

    // reset mid-settle discards partial count
    do_reset();
    cyc(4'b1011, 8'h66, 11);
    do_reset();
    chk("t5.dp", 32'(digit_dp), 32'd0);
    chk("t5.err", 32'(err), 32'd0);
    cyc(4'b1011, 8'h66, 17);
    chk("t5.early", 32'(digit_sts[5:4]), 32'd0);
    cyc(4'b1011, 8'h66, 1);
    chk("t5.sts", 32'(digit_sts[5:4]), 32'd1);
    chk("t5.val", 32'(digit_val[11:8]), 32'd4);

    // digit 2 starved: no frame until it latches
    do_reset();
    fd_seen = 0;
    for (int r = 0; r < 3; r++) begin
      cyc(4'b1110, 8'h06, 20);
      cyc(4'b1111, 8'h00, 3);
      cyc(4'b1101, 8'h4F, 20);
      cyc(4'b1111, 8'h00, 3);
      cyc(4'b1111, 8'h00, 20);
      cyc(4'b0111, 8'h7F, 20);
      cyc(4'b1111, 8'h00, 3);
    end
    chk("t6.nofd", 32'(fd_seen), 32'd0);
    cyc(4'b1011, 8'h6D, 20);
    cyc(4'b1111, 8'h00, 3);
    chk("t6.fd", 32'(fd_seen), 32'd1);
    chk("t6.val", 32'(digit_val[11:8]), 32'd5);

    // random traffic against the model
    do_reset();
    repeat (120) begin
      int r;
      int i;
      int j;
      r = $urandom_range(0, 9);
      a = '1;
      if (r < 6) begin
        a[$urandom_range(0, ND - 1)] = 1'b0;
      end else if (r >= 8) begin
        i = $urandom_range(0, ND - 1);
        j = (i + 1 + $urandom_range(0, ND - 2)) % ND;
        a[i] = 1'b0;
        a[j] = 1'b0;
      end
      r = $urandom_range(0, 9);
      if (r < 7)
        s = {1'($urandom_range(0, 1)), PATS[$urandom_range(0, 9)]};
      else if (r == 7)
        s = {1'($urandom_range(0, 1)), 7'h40};
      else if (r == 8)
        s = 8'h00;
      else
        s = 8'($urandom);
      cyc(a, s, $urandom_range(1, 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
